// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pixel clock-enable and delayed sync/strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int PIPE_DELAY = 4,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);
  localparam int HS0 = H_DISPLAY + H_FRONT;
  localparam int HS1 = HS0 + H_SYNC;
  localparam int H_TOTAL = HS1 + H_BACK;
  localparam int VS0 = V_DISPLAY + V_FRONT;
  localparam int VS1 = VS0 + V_SYNC;
  localparam int V_TOTAL = VS1 + V_BACK;
  localparam logic HP = HSYNC_POL != 0;
  localparam logic VP = VSYNC_POL != 0;
  localparam logic [4:0] RAW_RST = {1'b0, !HP, !VP, 2'b00};
  if (CW < 1 || CW > 31) $error("CW must be 1..31");
  if (CW < 31 && H_TOTAL > (1 << CW)) $error("H_TOTAL exceeds 2**CW");
  if (CW < 31 && V_TOTAL > (1 << CW)) $error("V_TOTAL exceeds 2**CW");
  if (H_SYNC < 1 || V_SYNC < 1) $error("sync width must be nonzero");
  if (PIPE_DELAY < 0 || PIPE_DELAY > 8) $error("PIPE_DELAY must be 0..8");
  int xi, yi;
  logic x_end, y_end;
  logic [4:0] raw, out;
  assign xi = int'(pixel_x);
  assign yi = int'(pixel_y);
  assign x_end = xi == H_TOTAL - 1;
  assign y_end = yi == V_TOTAL - 1;
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (pix_ce) begin
      pixel_x <= x_end ? '0 : pixel_x + 1'b1;
      if (x_end) pixel_y <= y_end ? '0 : pixel_y + 1'b1;
    end
  end
  // {video, hsync, vsync, line, frame} travel together so they stay aligned
  assign raw = {
    xi < H_DISPLAY && yi < V_DISPLAY,
    (xi >= HS0 && xi < HS1) ? HP : !HP,
    (yi >= VS0 && yi < VS1) ? VP : !VP,
    xi == 0,
    xi == 0 && yi == 0
  };
  if (PIPE_DELAY == 0) begin : g_nopipe
    assign out = raw;
  end else begin : g_pipe
    logic [PIPE_DELAY-1:0][4:0] pipe;
    always_ff @(posedge clk) begin
      if (reset) pipe <= {PIPE_DELAY{RAW_RST}};
      else if (pix_ce) begin
        pipe[0] <= raw;
        for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign out = pipe[PIPE_DELAY-1];
  end
  assign {video_on, hsync, vsync, line_start, frame_start} = out;
`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) frame_cnt <= '0;
    else if (pix_ce && x_end && y_end) frame_cnt <= frame_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen; three parameter sets share one stimulus stream.
module tb_vga_timing_gen;
  typedef struct packed {
    logic [15:0] x, y, fc;
    logic vid, hs, vs, ls, fs;
  } exp_t;
  logic clk = 1'b0;
  logic rst, pix_ce;
  logic [9:0] d_x, d_y;
  logic [3:0] s_x, s_y, m_x, m_y;
  logic d_vid, d_hs, d_vs, d_ls, d_fs;
  logic s_vid, s_hs, s_vs, s_ls, s_fs;
  logic m_vid, m_hs, m_vs, m_ls, m_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc, m_fc;
`endif
  exp_t q_def[$], q_sm[$], q_md[$];
  int n = 0, n_chk = 0, n_fail = 0, hw_cnt = 0, hw_exp = 96;
  bit fc_chk = 1'b1;
  always #5 clk = ~clk;
  vga_timing_gen u_def (
    .clk(clk), .reset(rst), .pix_ce(pix_ce), .pixel_x(d_x), .pixel_y(d_y),
    .video_on(d_vid), .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );
  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .PIPE_DELAY(0), .CW(4)
  ) u_sm (
    .clk(clk), .reset(rst), .pix_ce(pix_ce), .pixel_x(s_x), .pixel_y(s_y),
    .video_on(s_vid), .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );
  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PIPE_DELAY(4), .CW(4)
  ) u_md (
    .clk(clk), .reset(rst), .pix_ce(pix_ce), .pixel_x(m_x), .pixel_y(m_y),
    .video_on(m_vid), .hsync(m_hs), .vsync(m_vs), .line_start(m_ls), .frame_start(m_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(m_fc)
`endif
  );
  // n = pixel steps since reset; delayed outputs reflect the counters of step n - pd
  function automatic exp_t model(int n, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb, bit hp, bit vp, int pd);
    int ht = hd + hf + hs + hb;
    int vt = vd + vf + vs + vb;
    int m = n - pd;
    int mx, my;
    exp_t e;
    e.x = 16'(n % ht);
    e.y = 16'((n / ht) % vt);
    e.fc = 16'(n / (ht * vt));
    if (m < 0) begin
      e.vid = 1'b0; e.hs = !hp; e.vs = !vp; e.ls = 1'b0; e.fs = 1'b0;
    end else begin
      mx = m % ht;
      my = (m / ht) % vt;
      e.vid = mx < hd && my < vd;
      e.hs = (mx >= hd + hf && mx < hd + hf + hs) ? hp : !hp;
      e.vs = (my >= vd + vf && my < vd + vf + vs) ? vp : !vp;
      e.ls = mx == 0;
      e.fs = mx == 0 && my == 0;
    end
    return e;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cmp(input string p, input exp_t e, input logic [15:0] x, input logic [15:0] y,
                     input logic [4:0] o);
    check({p, "_x"}, 32'(x), 32'(e.x));
    check({p, "_y"}, 32'(y), 32'(e.y));
    check({p, "_video_on"}, 32'(o[4]), 32'(e.vid));
    check({p, "_hsync"}, 32'(o[3]), 32'(e.hs));
    check({p, "_vsync"}, 32'(o[2]), 32'(e.vs));
    check({p, "_line_start"}, 32'(o[1]), 32'(e.ls));
    check({p, "_frame_start"}, 32'(o[0]), 32'(e.fs));
  endtask
  task automatic step(input bit ce, input bit r);
    pix_ce = ce;
    rst = r;
    n = r ? 0 : (ce ? n + 1 : n);
    q_def.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 4));
    q_sm.push_back(model(n, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 0));
    q_md.push_back(model(n, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0, 4));
    @(negedge clk);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q_def.size() != 0) begin
        e = q_def.pop_front();
        cmp("def", e, 16'(d_x), 16'(d_y), {d_vid, d_hs, d_vs, d_ls, d_fs});
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (fc_chk) check("def_frame_cnt", 32'(d_fc), 32'(e.fc));
`endif
        e = q_sm.pop_front();
        cmp("sm", e, 16'(s_x), 16'(s_y), {s_vid, s_hs, s_vs, s_ls, s_fs});
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (fc_chk) check("sm_frame_cnt", 32'(s_fc), 32'(e.fc));
`endif
        e = q_md.pop_front();
        cmp("md", e, 16'(m_x), 16'(m_y), {m_vid, m_hs, m_vs, m_ls, m_fs});
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (fc_chk) check("md_frame_cnt", 32'(m_fc), 32'(e.fc));
`endif
        // hsync low-run width on the default instance, in clk cycles
        if (rst) hw_cnt = 0;
        else if (!d_hs) hw_cnt++;
        else if (hw_cnt != 0) begin
          check("def_hsync_width", 32'(hw_cnt), 32'(hw_exp));
          hw_cnt = 0;
        end
      end
    end
  end
  initial begin
    repeat (3) step(1'b1, 1'b1);
    repeat (1700) step(1'b1, 1'b0);
    hw_exp = 192;
    for (int i = 0; i < 1700; i++) step(i % 2 == 0, 1'b0);
    hw_exp = 96;
    repeat (150) step(1'b1, 1'b0);
    check("def_x_before_reset", 32'(d_x), 32'd300);
    step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (294) step(1'b1, 1'b0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("sm_frame_cnt_3", 32'(s_fc), 32'd3);
`endif
    repeat (97) step(1'b1, 1'b0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc_chk = 1'b0;
    force u_sm.frame_cnt = 16'hFFFF;
    step(1'b0, 1'b0);
    release u_sm.frame_cnt;
    #1;
    check("sm_frame_cnt_preset", 32'(s_fc), 32'hFFFF);
    step(1'b1, 1'b0);
    check("sm_frame_cnt_wrap", 32'(s_fc), 32'd0);
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
